// File: rtl/led_flow_pkg.sv
// led_flow_pkg
// Shared definitions for the flowing-LED sequencer:
//   - state_e     : FSM state encoding (IDLE / RUN / HOLD)
//   - MODE_WRAP / MODE_BOUNCE : values of the Mode input
//   - T_STEP_DEFAULT : default cycles per step (500 ms at 50 MHz)
package led_flow_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  localparam logic MODE_WRAP   = 1'b0;
  localparam logic MODE_BOUNCE = 1'b1;

  localparam int unsigned T_STEP_DEFAULT = 25_000_000;

endpackage

// File: rtl/led_flow_module_step_timebase.sv
// step_timebase
// Step period counter for the flowing-LED sequencer.
// Ports:
//   CLK  in  system clock, rising edge
//   RST  in  synchronous active-high reset
//   Run  in  count enable (RUN state with En high)
//   Clr  in  synchronous clear to 0, wins over Run
//   Tc   out terminal count: high in the cycle the counter is at T_STEP-1
//            while Run is high; the counter wraps to 0 on that edge
module step_timebase
  import led_flow_pkg::*;
#(
  parameter int unsigned T_STEP = T_STEP_DEFAULT,
  parameter int          CNT_W  = 25
) (
  input  logic CLK,
  input  logic RST,
  input  logic Run,
  input  logic Clr,
  output logic Tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_end;

  assign at_end = (cnt_q == CNT_W'(T_STEP - 1));

  // With Run low the count is frozen, which is what lets HOLD resume
  // mid-period instead of restarting the step.
  always_comb begin
    cnt_d = cnt_q;
    if (Clr) begin
      cnt_d = '0;
    end else if (Run) begin
      cnt_d = at_end ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign Tc = Run && !Clr && at_end;

endmodule

// File: rtl/led_flow_module.sv
// led_flow_module
// Walks a single lit LED across LED_NUM outputs, one position per T_STEP
// cycles, in wrap or bounce patterns, with pause (HOLD) and Clear.
// Optional feature macro: LED_FLOW_TRAIL_EN -- also lights the previous
// position, giving a two-LED trail.
// Ports:
//   CLK, RST   clock, synchronous active-high reset
//   En         run enable; low pauses (RUN -> HOLD)
//   Clear      synchronous return to IDLE
//   Dir        0 = increasing, 1 = decreasing position
//   Mode       0 = wrap, 1 = bounce
//   LED_Out    registered active-high LED drive
//   Pos        current lit position
//   Step_Tick  one-cycle pulse, coincident with each new Pos
//   Busy       registered, high in RUN or HOLD
//   State_Dbg  current FSM state (state_e encoding)
module led_flow_module
  import led_flow_pkg::*;
#(
  parameter int          LED_NUM = 4,
  parameter int unsigned T_STEP  = T_STEP_DEFAULT,
  parameter int          CNT_W   = 25,
  parameter int          POS_W   = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               En,
  input  logic               Clear,
  input  logic               Dir,
  input  logic               Mode,
  output logic [LED_NUM-1:0] LED_Out,
  output logic [POS_W-1:0]   Pos,
  output logic               Step_Tick,
  output logic               Busy,
  output logic [1:0]         State_Dbg
);

  localparam logic [POS_W-1:0] POS_MAX    = POS_W'(LED_NUM - 1);
  localparam logic [POS_W-1:0] POS_MAX_M1 = POS_W'(LED_NUM - 2);

  state_e             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               dir_q, dir_d;     // bounce direction flag, 1 = down
  logic               lmode_q, lmode_d; // Mode used at the last step/entry
  logic               tick_q, tick_d;
  logic               busy_q, busy_d;
  logic [LED_NUM-1:0] led_q, led_d;
  logic               eff_dir;
  logic               tc;
`ifdef LED_FLOW_TRAIL_EN
  logic [POS_W-1:0]   prev_q, prev_d;
`endif

  step_timebase #(
    .T_STEP (T_STEP),
    .CNT_W  (CNT_W)
  ) u_timebase (
    .CLK (CLK),
    .RST (RST),
    .Run ((state_q == S_RUN) && En && !Clear),
    .Clr (Clear || (state_q == S_IDLE)),
    .Tc  (tc)
  );

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    lmode_d = lmode_q;
    tick_d  = 1'b0;
    eff_dir = dir_q;
`ifdef LED_FLOW_TRAIL_EN
    prev_d  = prev_q;
`endif
    if (Clear) begin
      state_d = S_IDLE;
      pos_d   = '0;
      dir_d   = 1'b0;
`ifdef LED_FLOW_TRAIL_EN
      prev_d  = '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (En) begin
            state_d = S_RUN;
            pos_d   = Dir ? POS_MAX : '0;
            dir_d   = Dir;
            lmode_d = Mode;
`ifdef LED_FLOW_TRAIL_EN
            prev_d  = Dir ? POS_MAX : '0;
`endif
          end
        end
        S_RUN: begin
          // En low wins over a coincident terminal count.
          if (!En) begin
            state_d = S_HOLD;
          end else if (tc) begin
            tick_d  = 1'b1;
            lmode_d = Mode;
`ifdef LED_FLOW_TRAIL_EN
            prev_d  = pos_q;
`endif
            if (Mode == MODE_WRAP) begin
              dir_d = Dir;
              if (!Dir) pos_d = (pos_q == POS_MAX) ? '0 : pos_q + 1'b1;
              else      pos_d = (pos_q == '0) ? POS_MAX : pos_q - 1'b1;
            end else begin
              // Switching into bounce takes the direction from Dir once.
              eff_dir = (lmode_q == MODE_WRAP) ? Dir : dir_q;
              if (!eff_dir) begin
                if (pos_q == POS_MAX) begin
                  pos_d = POS_MAX_M1;
                  dir_d = 1'b1;
                end else begin
                  pos_d = pos_q + 1'b1;
                  dir_d = 1'b0;
                end
              end else begin
                if (pos_q == '0) begin
                  pos_d = POS_W'(1);
                  dir_d = 1'b0;
                end else begin
                  pos_d = pos_q - 1'b1;
                  dir_d = 1'b1;
                end
              end
            end
          end
        end
        S_HOLD: begin
          if (En) state_d = S_RUN;
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  always_comb begin
    led_d = '0;
    for (int i = 0; i < LED_NUM; i++) begin
`ifdef LED_FLOW_TRAIL_EN
      led_d[i] = (state_d != S_IDLE) &&
                 ((pos_d == POS_W'(i)) || (prev_d == POS_W'(i)));
`else
      led_d[i] = (state_d != S_IDLE) && (pos_d == POS_W'(i));
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      lmode_q <= MODE_WRAP;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      led_q   <= '0;
`ifdef LED_FLOW_TRAIL_EN
      prev_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      lmode_q <= lmode_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
`ifdef LED_FLOW_TRAIL_EN
      prev_q  <= prev_d;
`endif
    end
  end

  assign LED_Out   = led_q;
  assign Pos       = pos_q;
  assign Step_Tick = tick_q;
  assign Busy      = busy_q;
  assign State_Dbg = state_q;

endmodule

// File: tb/tb_led_flow_module.sv
// tb_led_flow_module
// Directed bench for led_flow_module with LED_NUM=4, T_STEP=4.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_led_flow_module;

  logic       clk;
  logic       rst, en, clear, dir, mode;
  logic [3:0] led;
  logic [1:0] pos;
  logic       tick, busy;
  logic [1:0] st;

  int n_cmp  = 0;
  int n_fail = 0;

  int b_seq [8] = '{0, 1, 2, 3, 2, 1, 0, 1};
  int d_seq [5] = '{3, 2, 1, 0, 3};

  led_flow_module #(
    .LED_NUM (4),
    .T_STEP  (4),
    .CNT_W   (3),
    .POS_W   (2)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .En        (en),
    .Clear     (clear),
    .Dir       (dir),
    .Mode      (mode),
    .LED_Out   (led),
    .Pos       (pos),
    .Step_Tick (tick),
    .Busy      (busy),
    .State_Dbg (st)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    clear = 1'b1; en = 1'b0;
    step();
    clear = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; en = 1'b0; clear = 1'b0; dir = 1'b0; mode = 1'b0;
    step(); step();
    n_cmp++; if (led !== 4'b0000) begin n_fail++; $display("FAIL reset_led got %b want 0000", led); end
    n_cmp++; if (pos !== 2'd0)    begin n_fail++; $display("FAIL reset_pos got %0d want 0", pos); end
    n_cmp++; if (tick !== 1'b0)   begin n_fail++; $display("FAIL reset_tick got %b want 0", tick); end
    n_cmp++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (st !== 2'd0)     begin n_fail++; $display("FAIL reset_state got %0d want 0", st); end
    rst = 1'b0;
  endtask

  task automatic test_wrap_up();
    logic [3:0] e_led;
    int         e_pos, e_prev;
    logic       e_tick;
    go_idle();
    en = 1'b1; dir = 1'b0; mode = 1'b0;
    step();  // entry edge
    for (int k = 0; k < 20; k++) begin
      if (k > 0) step();
      e_pos  = (k / 4) % 4;
      e_prev = (k < 4) ? 0 : ((k / 4) + 3) % 4;
      e_tick = (k > 0) && (k % 4 == 0);
`ifdef LED_FLOW_TRAIL_EN
      e_led = 4'(1 << e_pos) | 4'(1 << e_prev);
`else
      e_led = 4'(1 << e_pos);
`endif
      n_cmp++; if (pos !== 2'(e_pos)) begin n_fail++; $display("FAIL wrap_pos k=%0d got %0d want %0d", k, pos, e_pos); end
      n_cmp++; if (led !== e_led)     begin n_fail++; $display("FAIL wrap_led k=%0d got %b want %b", k, led, e_led); end
      n_cmp++; if (tick !== e_tick)   begin n_fail++; $display("FAIL wrap_tick k=%0d got %b want %b", k, tick, e_tick); end
      n_cmp++; if (busy !== 1'b1)     begin n_fail++; $display("FAIL wrap_busy k=%0d got %b want 1", k, busy); end
    end
  endtask

  task automatic test_bounce();
    go_idle();
    en = 1'b1; dir = 1'b0; mode = 1'b1;
    step();
    dir = 1'b1;  // must be ignored once bouncing
    for (int s = 0; s < 8; s++) begin
      if (s > 0) begin
        for (int c = 0; c < 3; c++) begin
          step();
          n_cmp++; if (tick !== 1'b0) begin n_fail++; $display("FAIL bounce_notick s=%0d got %b want 0", s, tick); end
        end
        step();
        n_cmp++; if (tick !== 1'b1) begin n_fail++; $display("FAIL bounce_tick s=%0d got %b want 1", s, tick); end
      end
      n_cmp++; if (pos !== 2'(b_seq[s])) begin n_fail++; $display("FAIL bounce_pos s=%0d got %0d want %0d", s, pos, b_seq[s]); end
    end
  endtask

  task automatic test_wrap_down();
    go_idle();
    en = 1'b1; dir = 1'b1; mode = 1'b0;
    step();
    for (int s = 0; s < 5; s++) begin
      if (s > 0) repeat (4) step();
      n_cmp++; if (pos !== 2'(d_seq[s])) begin n_fail++; $display("FAIL down_pos s=%0d got %0d want %0d", s, pos, d_seq[s]); end
    end
    n_cmp++; if (led !== 4'b1000) begin n_fail++; $display("FAIL down_led got %b want 1000", led); end
  endtask

  task automatic test_hold();
    go_idle();
    en = 1'b1; dir = 1'b0; mode = 1'b0;
    step(); step(); step();  // counter now 2
    en = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (led !== 4'b0001) begin n_fail++; $display("FAIL hold_led i=%0d got %b want 0001", i, led); end
      n_cmp++; if (busy !== 1'b1)   begin n_fail++; $display("FAIL hold_busy i=%0d got %b want 1", i, busy); end
      n_cmp++; if (tick !== 1'b0)   begin n_fail++; $display("FAIL hold_tick i=%0d got %b want 0", i, tick); end
      n_cmp++; if (st !== 2'd2)     begin n_fail++; $display("FAIL hold_state i=%0d got %0d want 2", i, st); end
      if (i < 9) step();
    end
    en = 1'b1;
    step();  // resume edge
    n_cmp++; if (pos !== 2'd0 || tick !== 1'b0) begin n_fail++; $display("FAIL resume0 got pos=%0d tick=%b want pos=0 tick=0", pos, tick); end
    step();
    n_cmp++; if (pos !== 2'd0 || tick !== 1'b0) begin n_fail++; $display("FAIL resume1 got pos=%0d tick=%b want pos=0 tick=0", pos, tick); end
    step();
    n_cmp++; if (pos !== 2'd1 || tick !== 1'b1) begin n_fail++; $display("FAIL resume2 got pos=%0d tick=%b want pos=1 tick=1", pos, tick); end
  endtask

  task automatic test_en_at_tc_and_clear();
    go_idle();
    en = 1'b1; dir = 1'b0; mode = 1'b0;
    step(); step(); step(); step();  // counter now 3
    en = 1'b0;
    step();
    n_cmp++; if (tick !== 1'b0 || pos !== 2'd0) begin n_fail++; $display("FAIL tc_hold got pos=%0d tick=%b want pos=0 tick=0", pos, tick); end
    en = 1'b1;
    step();
    n_cmp++; if (tick !== 1'b0 || pos !== 2'd0) begin n_fail++; $display("FAIL tc_resume got pos=%0d tick=%b want pos=0 tick=0", pos, tick); end
    step();
    n_cmp++; if (tick !== 1'b1 || pos !== 2'd1) begin n_fail++; $display("FAIL tc_advance got pos=%0d tick=%b want pos=1 tick=1", pos, tick); end
    step();
    clear = 1'b1;
    step();
    clear = 1'b0; en = 1'b0;
    n_cmp++; if (led !== 4'b0000) begin n_fail++; $display("FAIL clear_led got %b want 0000", led); end
    n_cmp++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL clear_busy got %b want 0", busy); end
    n_cmp++; if (pos !== 2'd0)    begin n_fail++; $display("FAIL clear_pos got %0d want 0", pos); end
    n_cmp++; if (st !== 2'd0)     begin n_fail++; $display("FAIL clear_state got %0d want 0", st); end
  endtask

  task automatic test_reset_mid();
    go_idle();
    en = 1'b1; dir = 1'b0; mode = 1'b0;
    repeat (7) step();  // pos 1, counter 2
    n_cmp++; if (pos !== 2'd1) begin n_fail++; $display("FAIL rmid_pre got %0d want 1", pos); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (led !== 4'b0000 || pos !== 2'd0 || tick !== 1'b0 || busy !== 1'b0)
      begin n_fail++; $display("FAIL rmid_out got led=%b pos=%0d tick=%b busy=%b want all 0", led, pos, tick, busy); end
    step();  // re-entry edge, count restarts from 0
    for (int i = 1; i <= 4; i++) begin
      step();
      n_cmp++; if (tick !== (i == 4)) begin n_fail++; $display("FAIL rmid_tick i=%0d got %b want %b", i, tick, (i == 4)); end
    end
    n_cmp++; if (pos !== 2'd1) begin n_fail++; $display("FAIL rmid_pos got %0d want 1", pos); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1; en = 1'b0; clear = 1'b0; dir = 1'b0; mode = 1'b0;
    test_reset();
    test_wrap_up();
    test_bounce();
    test_wrap_down();
    test_hold();
    test_en_at_tc_and_clear();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/led_flow_module.md
Name: led_flow_module

Overview:
- Flowing-LED sequencer downstream of the single-LED timing block in the FLOWLED design.
- Owns its own step timebase and walks a single lit LED across LED_NUM outputs.
- Supports wrap and bounce patterns with pause/resume and clear.
- Its LED_Out drives board LED pins directly; Step_Tick is available to neighbouring blocks for synchronisation.

Parameters:
- LED_NUM, 4, number of LEDs driven; must be >= 2.
- T_STEP, 25'd25_000_000, clock cycles per step (500 ms at 50 MHz); must be >= 2.
- CNT_W, 25, timebase counter width; must hold T_STEP-1.
- POS_W, 2, position width; equals clog2(LED_NUM).

Ports:
- CLK, input, 1, system clock; all logic on the rising edge.
- RST, input, 1, synchronous active-high reset.
- En, input, 1, run enable; 0 pauses the sequence.
- Clear, input, 1, synchronous return to idle.
- Dir, input, 1, 0 = increasing position, 1 = decreasing position.
- Mode, input, 1, 0 = wrap, 1 = bounce.
- LED_Out, output, LED_NUM, registered LED drive, active high.
- Pos, output, POS_W, current lit position.
- Step_Tick, output, 1, one-cycle pulse on each position advance.
- Busy, output, 1, high in RUN or HOLD.

Behaviour:
- Reset (RST=1 at a clock edge):
  - state=IDLE, counter=0, Pos=0, LED_Out=0, Step_Tick=0, Busy=0, internal direction flag=0.
- Priority at every edge: RST > Clear > En/step logic.
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - LED_Out=0 and counter held at 0.
  - En=1 -> RUN. On that edge: Pos=0 if Dir=0, else LED_NUM-1.
  - LED_Out becomes one-hot(Pos) on the same edge (registered, so visible the next cycle).
  - The direction flag is loaded from Dir on the same edge.
- RUN:
  - Counter increments each cycle.
  - When counter==T_STEP-1: counter->0, Pos advances, LED_Out updates, Step_Tick=1 for that one cycle.
  - First advance therefore occurs T_STEP cycles after entering RUN.
- HOLD:
  - Entered from RUN when En=0.
  - Counter, Pos and LED_Out frozen; Step_Tick=0.
  - En=1 -> RUN, resuming from the frozen counter value (no restart of the step period).
- Clear=1 in any state -> IDLE with counter=0, Pos=0, LED_Out=0, Step_Tick=0.
- En=0 in RUN on the exact cycle counter==T_STEP-1: HOLD wins; no advance and no tick.
- Wrap mode (Mode=0):
  - Dir is sampled at every step.
  - Dir=0: Pos+1, with LED_NUM-1 -> 0.
  - Dir=1: Pos-1, with 0 -> LED_NUM-1.
- Bounce mode (Mode=1):
  - Dir is ignored after entry; the direction flag governs movement.
  - Moving up at Pos=LED_NUM-1: next Pos=LED_NUM-2 and the flag flips to down.
  - Moving down at Pos=0: next Pos=1 and the flag flips to up.
  - LED_Out never leaves the range 0..LED_NUM-1.
- Mode changes mid-run:
  - Take effect at the next step.
  - On a switch to bounce, the flag is loaded from Dir at that step.
- Busy is registered; it is high while state is RUN or HOLD.
- Pos is never outside 0..LED_NUM-1, including when LED_NUM is not a power of two.
- Reset asserted mid-step discards the partial count.

Optional Feature:
- Macro: LED_FLOW_TRAIL_EN.
- When defined:
  - LED_Out = one-hot(Pos) | one-hot(Prev_Pos), where Prev_Pos is the position before the last advance.
  - Prev_Pos equals Pos until the first step after leaving IDLE, so exactly one LED is lit initially.
  - Clear and RST reset Prev_Pos to match Pos.
- When undefined:
  - Strictly one-hot LED_Out; no Prev_Pos register.

Decomposition:
- Shared package led_flow_pkg:
  - State encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_HOLD=2'd2.
  - Mode constants MODE_WRAP=1'b0, MODE_BOUNCE=1'b1.
  - Default T_STEP constant.
- Sub-module step_timebase: the counter plus the terminal-count pulse, with inputs CLK, RST, Run, Clr and output Tc.
  - The FSM and position logic stay in led_flow_module.

Test Plan (LED_NUM=4, T_STEP=4):
- Reset, then En=1, Dir=0, Mode=0 held 20 cycles -> LED_Out 0001 then 0010, 0100, 1000, 0001, each lasting 4 cycles; Step_Tick pulses every 4th cycle.
- Mode=1, Dir=0 for 40 cycles -> Pos sequence 0,1,2,3,2,1,0,1; no repeated endpoint.
- Dir=1, Mode=0 from IDLE -> Pos starts at 3, then 3,2,1,0,3.
- En dropped when counter=2 for 10 cycles, then raised -> LED_Out frozen and Busy=1 during HOLD; the next advance occurs 2 cycles after resume.
- En=0 exactly at counter=3 -> no Step_Tick and Pos unchanged; Clear pulse in RUN -> next cycle LED_Out=0, Busy=0, Pos=0.
- With LED_FLOW_TRAIL_EN, wrap mode Dir=0 -> 0001, 0011, 0110, 1100, 1001; RST mid-run -> all outputs 0 on the next cycle.
